// File: rtl/iob_reg_pipe_pkg.sv
// iob_reg_pipe shared defaults and helpers.
// Parameter defaults for the elastic pipeline register.
package iob_reg_pipe_pkg;

  localparam int DATA_W_DEF = 21;
  localparam int DEPTH_DEF  = 2;

  // Width needed to count 0..depth occupied stages
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/iob_reg_pipe_stage.sv
// One pipeline stage: valid bit plus data register.
// Data only loads with a valid word, so bubbles leave it untouched.
module iob_reg_pipe_stage
  import iob_reg_pipe_pkg::*;
#(
  parameter int                DATA_W  = DATA_W_DEF,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              ld_i,
  input  logic              v_i,
  input  logic [DATA_W-1:0] d_i,
  output logic              v_o,
  output logic [DATA_W-1:0] d_o
);

  logic              v_q, v_d;
  logic [DATA_W-1:0] d_q, d_d;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush_i) begin
      v_d = 1'b0;
      d_d = RST_VAL;
    end else if (ld_i) begin
      v_d = v_i;
      if (v_i) d_d = d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q <= 1'b0;
      d_q <= RST_VAL;
    end else if (cke_i) begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v_o = v_q;
  assign d_o = d_q;

endmodule

// File: rtl/iob_reg_pipe.sv
// Elastic pipeline register with valid/ready handshake,
// bubble collapsing, flush and occupancy count.
module iob_reg_pipe
  import iob_reg_pipe_pkg::*;
#(
  parameter int                DATA_W  = DATA_W_DEF,
  parameter int                DEPTH   = DEPTH_DEF,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                     clk_i,
  input  logic                     cke_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     i_valid_i,
  output logic                     i_ready_o,
  input  logic [DATA_W-1:0]        i_data_i,
  output logic                     o_valid_o,
  input  logic                     o_ready_i,
  output logic [DATA_W-1:0]        o_data_o,
  output logic [lvl_w(DEPTH)-1:0]  level_o
);

  localparam int LW = lvl_w(DEPTH);

  logic [DEPTH-1:0]  v;
  logic [DEPTH-1:0]  r;
  logic [DATA_W-1:0] d [DEPTH];
  logic              all_v;
  logic              act;
  logic              in_x, out_x;
  logic [LW-1:0]     level_q, level_d;

  assign act = cke_i & ~flush_i & ~rst_i;

  // Stage k can load unless it and every stage ahead is full
  // while the output is stalled.
  always_comb begin
    r     = '0;
    all_v = 1'b1;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      all_v = all_v & v[k];
      r[k]  = o_ready_i | ~all_v;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stg
    logic              vin;
    logic [DATA_W-1:0] din;
    if (k == 0) begin : g_in
      assign vin = i_valid_i;
      assign din = i_data_i;
    end else begin : g_mid
      assign vin = v[k-1];
      assign din = d[k-1];
    end
    iob_reg_pipe_stage #(
      .DATA_W  (DATA_W),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk_i   (clk_i),
      .cke_i   (cke_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .ld_i    (r[k]),
      .v_i     (vin),
      .d_i     (din),
      .v_o     (v[k]),
      .d_o     (d[k])
    );
  end

  assign i_ready_o = r[0] & act;
  assign o_valid_o = v[DEPTH-1] & act;
  assign o_data_o  = d[DEPTH-1];

  assign in_x  = i_valid_i & i_ready_o;
  assign out_x = o_valid_o & o_ready_i;

  always_comb begin
    level_d = level_q;
    if (flush_i)
      level_d = '0;
    else if (in_x & ~out_x)
      level_d = level_q + LW'(1);
    else if (out_x & ~in_x)
      level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      level_q <= '0;
    else if (cke_i)
      level_q <= level_d;
  end

  assign level_o = level_q;

endmodule
